// File: rtl/timer_pkg.sv
// Shared types and default field limits for the elapsed timer.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } timer_state_t;

  localparam int DEF_SEC_MAX = 59;
  localparam int DEF_MIN_MAX = 59;
  localparam int DEF_HR_MAX  = 23;
  localparam int DEF_FW      = 6;

endpackage

// File: rtl/elapsed_timer_if.sv
// Command and status bundle between the elapsed timer and whoever drives it.
interface elapsed_timer_if import timer_pkg::*; #(
  parameter int FW = DEF_FW
);

  logic            tick;
  logic            start;
  logic            stop;
  logic            clear;
  logic            load;
  logic [3*FW-1:0] load_value;
  logic            dir;
  logic            lap;
  logic [3*FW-1:0] time_out;
  logic [3*FW-1:0] lap_out;
  logic            running;
  logic            expired;
  logic            wrap;

  modport master (
    output tick, start, stop, clear, load, load_value, dir, lap,
    input  time_out, lap_out, running, expired, wrap
  );

  modport slave (
    input  tick, start, stop, clear, load, load_value, dir, lap,
    output time_out, lap_out, running, expired, wrap
  );

endinterface

// File: rtl/digit_counter.sv
// One modulo-(MAX+1) field of the timer with combinational carry/borrow out.
module digit_counter #(
  parameter int MAX = 59,
  parameter int FW  = 6
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          inc,
  input  logic          dec,
  input  logic          clr,
  input  logic          ld,
  input  logic [FW-1:0] ld_val,
  output logic [FW-1:0] value,
  output logic          carry,
  output logic          borrow
);

  localparam logic [FW-1:0] MAX_V = FW'(MAX);

  assign carry  = inc && (value == MAX_V);
  assign borrow = dec && (value == '0);

  // Loaded values beyond the field's range saturate rather than wrap.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)       value <= '0;
    else if (clr)    value <= '0;
    else if (ld)     value <= (ld_val > MAX_V) ? MAX_V : ld_val;
    else if (inc)    value <= carry ? '0 : value + FW'(1);
    else if (dec)    value <= borrow ? MAX_V : value - FW'(1);
  end

endmodule

// File: rtl/elapsed_timer.sv
// Hours/minutes/seconds stopwatch-countdown with lap capture, built from three chained fields.
module elapsed_timer import timer_pkg::*; #(
  parameter int SEC_MAX = DEF_SEC_MAX,
  parameter int MIN_MAX = DEF_MIN_MAX,
  parameter int HR_MAX  = DEF_HR_MAX,
  parameter int FW      = DEF_FW
) (
  input  logic            clk,
  input  logic            nrst,
  elapsed_timer_if.slave  bus
);

  localparam int BIGGEST = (SEC_MAX > MIN_MAX) ? ((SEC_MAX > HR_MAX) ? SEC_MAX : HR_MAX)
                                               : ((MIN_MAX > HR_MAX) ? MIN_MAX : HR_MAX);

  if (FW < $clog2(BIGGEST + 1)) begin : g_fw_check
    $error("elapsed_timer: FW too narrow for the field limits");
  end

  timer_state_t    state, state_next;
  logic [FW-1:0]   sec, min, hr;
  logic            sec_carry, sec_borrow, min_carry, min_borrow, hr_carry, hr_borrow;
  logic            count_en, inc_sec, dec_sec, ld_en, clr_all;
  logic            wrap_q, running, expired;
  logic [3*FW-1:0] lap_q, time_now;

  // Any higher-priority command in the same cycle swallows the tick.
  assign count_en = (state == RUN) && bus.tick && !bus.clear && !bus.load
                    && !bus.stop && !bus.start;
  assign inc_sec  = count_en && !bus.dir;
  assign dec_sec  = count_en && bus.dir;
  assign ld_en    = bus.load && !bus.clear;
  // A borrow out of the hours field means a down tick at 0:00:00; clearing holds zero.
  assign clr_all  = bus.clear || hr_borrow;
  assign time_now = {hr, min, sec};

  digit_counter #(.MAX(SEC_MAX), .FW(FW)) u_sec (
    .clk(clk), .nrst(nrst), .inc(inc_sec), .dec(dec_sec), .clr(clr_all), .ld(ld_en),
    .ld_val(bus.load_value[FW-1:0]), .value(sec), .carry(sec_carry), .borrow(sec_borrow)
  );

  digit_counter #(.MAX(MIN_MAX), .FW(FW)) u_min (
    .clk(clk), .nrst(nrst), .inc(sec_carry), .dec(sec_borrow), .clr(clr_all), .ld(ld_en),
    .ld_val(bus.load_value[2*FW-1:FW]), .value(min), .carry(min_carry), .borrow(min_borrow)
  );

  digit_counter #(.MAX(HR_MAX), .FW(FW)) u_hr (
    .clk(clk), .nrst(nrst), .inc(min_carry), .dec(min_borrow), .clr(clr_all), .ld(ld_en),
    .ld_val(bus.load_value[3*FW-1:2*FW]), .value(hr), .carry(hr_carry), .borrow(hr_borrow)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (bus.clear) begin
      state_next = IDLE;
    end else if (bus.load) begin
      if (state == EXPIRED) state_next = IDLE;
    end else if (bus.stop) begin
      if (state == RUN) state_next = PAUSE;
    end else if (bus.start) begin
      if (state == IDLE || state == PAUSE) state_next = RUN;
    end else if (hr_borrow) begin
      state_next = EXPIRED;
    end
  end

  always_comb begin
    running = (state == RUN);
    expired = (state == EXPIRED);
  end

  // Lap captures the pre-update count; a simultaneous clear wins.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      lap_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= hr_carry;
      if (bus.clear)    lap_q <= '0;
      else if (bus.lap) lap_q <= time_now;
    end
  end

  assign bus.time_out = time_now;
  assign bus.lap_out  = lap_q;
  assign bus.running  = running;
  assign bus.expired  = expired;
  assign bus.wrap     = wrap_q;

endmodule

// File: tb/tb_elapsed_timer.sv
// Randomized plus directed bench; a seconds-since-midnight model feeds a scoreboard checked by a monitor.
module tb_elapsed_timer;

  localparam int FW       = 6;
  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HR_MAX   = 23;
  localparam int SPAN_SEC = SEC_MAX + 1;
  localparam int SPAN_MIN = MIN_MAX + 1;
  localparam int TOTAL    = SPAN_SEC * SPAN_MIN * (HR_MAX + 1);

  typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_EXPIRED} mstate_t;

  typedef struct packed {
    logic [17:0] time_v;
    logic [17:0] lap_v;
    logic        running;
    logic        expired;
    logic        wrap;
  } exp_t;

  logic    clk;
  logic    nrst;
  int      checks;
  int      errors;
  exp_t    sb[$];
  int      m_total;
  logic [17:0] m_lap;
  mstate_t m_state;
  bit      rdir;
  logic [17:0] rlv;

  elapsed_timer_if #(.FW(FW)) bus ();

  elapsed_timer #(.SEC_MAX(SEC_MAX), .MIN_MAX(MIN_MAX), .HR_MAX(HR_MAX), .FW(FW)) dut (
    .clk(clk),
    .nrst(nrst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [17:0] hms(input int h, input int m, input int s);
    return {6'(h), 6'(m), 6'(s)};
  endfunction

  function automatic logic [17:0] to_fields(input int t);
    return hms(t / (SPAN_SEC * SPAN_MIN), (t / SPAN_SEC) % SPAN_MIN, t % SPAN_SEC);
  endfunction

  function automatic int from_fields(input logic [17:0] v);
    int h, m, s;
    h = int'(v[17:12]);
    m = int'(v[11:6]);
    s = int'(v[5:0]);
    if (h > HR_MAX)  h = HR_MAX;
    if (m > MIN_MAX) m = MIN_MAX;
    if (s > SEC_MAX) s = SEC_MAX;
    return (h * SPAN_MIN + m) * SPAN_SEC + s;
  endfunction

  task automatic check_output(input string name, input logic [17:0] act, input logic [17:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %b required %b", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_total = 0;
    m_lap   = '0;
    m_state = M_IDLE;
  endtask

  // Drive one cycle of commands, advance the model, queue what the DUT must show after the edge.
  task automatic apply_stimulus(input bit tk, input bit st, input bit sp, input bit cl,
                                input bit ld, input bit dr, input bit lp, input logic [17:0] lv);
    exp_t e;
    bit   wrap_e;
    @(negedge clk);
    bus.tick = tk; bus.start = st; bus.stop = sp; bus.clear = cl;
    bus.load = ld; bus.dir = dr; bus.lap = lp; bus.load_value = lv;
    wrap_e = 1'b0;
    if (cl) begin
      model_reset();
    end else begin
      if (lp) m_lap = to_fields(m_total);
      if (ld) begin
        m_total = from_fields(lv);
        if (m_state == M_EXPIRED) m_state = M_IDLE;
      end else if (sp) begin
        if (m_state == M_RUN) m_state = M_PAUSE;
      end else if (st) begin
        if (m_state == M_IDLE || m_state == M_PAUSE) m_state = M_RUN;
      end else if (tk && m_state == M_RUN) begin
        if (!dr) begin
          if (m_total == TOTAL - 1) begin
            m_total = 0;
            wrap_e  = 1'b1;
          end else begin
            m_total++;
          end
        end else if (m_total == 0) begin
          m_state = M_EXPIRED;
        end else begin
          m_total--;
        end
      end
    end
    e.time_v  = to_fields(m_total);
    e.lap_v   = m_lap;
    e.running = (m_state == M_RUN);
    e.expired = (m_state == M_EXPIRED);
    e.wrap    = wrap_e;
    sb.push_back(e);
    @(posedge clk);
    #2;
    bus.tick = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
    bus.clear = 1'b0; bus.load = 1'b0; bus.lap = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_output("sb_time_out", bus.time_out, e.time_v);
        check_output("sb_lap_out", bus.lap_out, e.lap_v);
        check_bit("sb_running", bus.running, e.running);
        check_bit("sb_expired", bus.expired, e.expired);
        check_bit("sb_wrap", bus.wrap, e.wrap);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] simulation did not complete");
  end

  initial begin : main
    checks = 0;
    errors = 0;
    nrst = 1'b0;
    bus.tick = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; bus.clear = 1'b0;
    bus.load = 1'b0; bus.dir = 1'b0; bus.lap = 1'b0; bus.load_value = '0;
    model_reset();
    rdir = 1'b0;

    #3;
    check_output("rst_time_out", bus.time_out, '0);
    check_output("rst_lap_out", bus.lap_out, '0);
    check_bit("rst_running", bus.running, 1'b0);
    check_bit("rst_expired", bus.expired, 1'b0);
    check_bit("rst_wrap", bus.wrap, 1'b0);
    #4 nrst = 1'b1;

    $display("[TB] up-count carry");
    apply_stimulus(0, 0, 0, 0, 1, 0, 0, hms(0, 59, 58));
    apply_stimulus(0, 1, 0, 0, 0, 0, 0, '0);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, '0);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, '0);
    check_output("carry_time", bus.time_out, hms(1, 0, 0));

    $display("[TB] up-count wrap");
    apply_stimulus(0, 0, 0, 0, 1, 0, 0, hms(23, 59, 59));
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, '0);
    check_output("wrap_time", bus.time_out, '0);
    check_bit("wrap_pulse", bus.wrap, 1'b1);
    check_bit("wrap_running", bus.running, 1'b1);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, '0);
    check_bit("wrap_one_cycle", bus.wrap, 1'b0);

    $display("[TB] down-count expiry");
    apply_stimulus(0, 0, 0, 1, 0, 1, 0, '0);
    apply_stimulus(0, 0, 0, 0, 1, 1, 0, hms(0, 0, 2));
    apply_stimulus(0, 1, 0, 0, 0, 1, 0, '0);
    repeat (3) apply_stimulus(1, 0, 0, 0, 0, 1, 0, '0);
    check_output("expire_time", bus.time_out, '0);
    check_bit("expire_flag", bus.expired, 1'b1);
    apply_stimulus(0, 1, 0, 0, 0, 1, 0, '0);
    check_bit("expire_start_ignored", bus.expired, 1'b1);
    check_bit("expire_not_running", bus.running, 1'b0);

    $display("[TB] command priority");
    apply_stimulus(0, 0, 0, 0, 1, 0, 0, hms(5, 5, 5));
    apply_stimulus(0, 1, 0, 0, 0, 0, 0, '0);
    apply_stimulus(1, 0, 0, 1, 1, 0, 0, hms(9, 9, 9));
    check_output("prio_clear_time", bus.time_out, '0);
    check_bit("prio_clear_idle", bus.running, 1'b0);
    apply_stimulus(0, 1, 0, 0, 0, 0, 0, '0);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, '0);
    apply_stimulus(1, 0, 1, 0, 0, 0, 0, '0);
    check_output("prio_stop_time", bus.time_out, hms(0, 0, 1));
    check_bit("prio_stop_paused", bus.running, 1'b0);

    $display("[TB] lap capture");
    apply_stimulus(0, 0, 0, 1, 0, 0, 0, '0);
    apply_stimulus(0, 0, 0, 0, 1, 0, 0, hms(0, 0, 7));
    apply_stimulus(0, 1, 0, 0, 0, 0, 0, '0);
    apply_stimulus(1, 0, 0, 0, 0, 0, 1, '0);
    check_output("lap_value", bus.lap_out, hms(0, 0, 7));
    check_output("lap_time", bus.time_out, hms(0, 0, 8));

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) rdir = ~rdir;
      case ($urandom_range(0, 2))
        0:       rlv = 18'($urandom);
        1:       rlv = hms(23, 59, $urandom_range(55, 63));
        default: rlv = hms(0, 0, $urandom_range(0, 4));
      endcase
      apply_stimulus(1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0,
                     $urandom_range(0, 19) == 0, $urandom_range(0, 59) == 0,
                     $urandom_range(0, 24) == 0, rdir, $urandom_range(0, 9) == 0, rlv);
    end

    $display("[TB] asynchronous reset mid-run");
    apply_stimulus(0, 0, 0, 0, 1, 0, 0, hms(3, 12, 45));
    apply_stimulus(0, 1, 0, 0, 0, 0, 1, '0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, '0);
    check_output("pre_reset_time", bus.time_out, hms(3, 12, 45));
    check_bit("pre_reset_running", bus.running, 1'b1);
    #1 nrst = 1'b0;
    #1;
    check_output("async_rst_time", bus.time_out, '0);
    check_output("async_rst_lap", bus.lap_out, '0);
    check_bit("async_rst_running", bus.running, 1'b0);
    check_bit("async_rst_expired", bus.expired, 1'b0);
    check_bit("async_rst_wrap", bus.wrap, 1'b0);
    #3 nrst = 1'b1;
    model_reset();

    apply_stimulus(0, 1, 0, 0, 0, 0, 0, '0);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, '0);
    check_output("post_reset_count", bus.time_out, hms(0, 0, 1));

    repeat (2) @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
